// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: holds the instruction register and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB so one memory port serves both
// instruction and data traffic. Latency: branch/NOP 3, ALU op/store 4, load 5
// cycles with zero wait states. Backpressure: FETCH and MEM stall while
// mem_ready_i is low; the FSM advances on the cycle mem_ready_i is high.
//
// Optional build macro: MCU_ILLEGAL_TRAP_EN. When defined, unsupported
// opcode/funct3/funct7 combinations enter a terminal TRAP state (code 5) that
// holds with all strobes low until reset. When undefined, they retire as NOPs.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   mem_rdata_i         memory read data, latched into IR on a FETCH handshake
//   mem_ready_i         memory completes the current request this cycle
//   cond_i              branch comparison result from the ALU
//   ir_o, state_o       instruction register and FSM state code
//   mem_req_o/we_o      memory request / write strobe
//   mem_addr_sel_o      memory address mux: 0=PC, 1=ALU result
//   ir_write_o          IR load strobe
//   pc_write_o/src_o    PC update strobe and source (0=PC+4, 1=branch target)
//   alu_src_a_o/b_o     ALU operand muxes (a: 0=rs1,1=PC; b: 0=rs2,1=imm)
//   alu_op_o            ALU operation code (zero-extended to ALUOP_W)
//   reg_write_o         register-file write strobe
//   mem_to_reg_o        writeback mux: 1=memory data
//   retire_o            one-cycle pulse when an instruction completes
//   retire_cnt_o        retired-instruction counter (wraps)

module multicycle_control_unit #(
  parameter int          ALUOP_W  = 4,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] RESET_IR = 32'h00000013
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        mem_rdata_i,
  input  logic               mem_ready_i,
  input  logic               cond_i,
  output logic [31:0]        ir_o,
  output logic [2:0]         state_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               mem_addr_sel_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               pc_src_o,
  output logic               alu_src_a_o,
  output logic               alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               reg_write_o,
  output logic               mem_to_reg_o,
  output logic               retire_o,
  output logic [CNT_W-1:0]   retire_cnt_o
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
`ifdef MCU_ILLEGAL_TRAP_EN
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
`else
    S_WB     = 3'd4
`endif
  } state_e;

  // Instruction classes after decode; CL_NOP covers unknown and illegal encodings.
  typedef enum logic [2:0] {
    CL_NOP    = 3'd0,
    CL_ALU_R  = 3'd1,
    CL_ALU_I  = 3'd2,
    CL_LOAD   = 3'd3,
    CL_STORE  = 3'd4,
    CL_BRANCH = 3'd5
  } class_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_SLTU = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_NE   = 4'hB;
  localparam logic [3:0] OP_GE   = 4'hC;
  localparam logic [3:0] OP_GEU  = 4'hD;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retire_cnt_q;

  // ---------------------------------------------------------------------------
  // Instruction decode (from the held IR)
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Shared funct3 -> op mapping for register and immediate ALU forms.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] branch_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_EQ;
      3'b001:  op = OP_NE;
      3'b100:  op = OP_SLT;
      3'b101:  op = OP_GE;
      3'b110:  op = OP_SLTU;
      default: op = OP_GEU;
    endcase
    return op;
  endfunction

  class_e     cls_raw;
  class_e     cls;
  logic       legal;
  logic [3:0] dec_op;
  logic       dec_src_b;

  always_comb begin
    cls_raw = CL_NOP;
    legal   = 1'b1;
    dec_op  = OP_ADD;
    case (opcode)
      OPC_R: begin
        // funct7=0x20 only selects SUB/SRA; any other funct7 is unsupported.
        if (funct7 == 7'h00) begin
          cls_raw = CL_ALU_R;
          dec_op  = base_op(funct3);
        end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
          cls_raw = CL_ALU_R;
          dec_op  = OP_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
          cls_raw = CL_ALU_R;
          dec_op  = OP_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_I: begin
        // Immediate bit 30 only means "arithmetic" for shifts-right; for the
        // other funct3 values it is just a sign bit and must not pick SUB.
        cls_raw = CL_ALU_I;
        if (funct3 == 3'b101 && funct7[5]) dec_op = OP_SRA;
        else                               dec_op = base_op(funct3);
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) cls_raw = CL_LOAD;
        else                  legal   = 1'b0;
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) cls_raw = CL_STORE;
        else                  legal   = 1'b0;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b010 || funct3 == 3'b011) begin
          legal = 1'b0;
        end else begin
          cls_raw = CL_BRANCH;
          dec_op  = branch_op(funct3);
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal encodings collapse to NOP so EXEC retires them when no trap exists.
  assign cls       = legal ? cls_raw : CL_NOP;
  assign dec_src_b = (cls == CL_ALU_I) || (cls == CL_LOAD) || (cls == CL_STORE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) begin
          ir_d    = mem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef MCU_ILLEGAL_TRAP_EN
        state_d = legal ? S_EXEC : S_TRAP;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        case (cls)
          CL_ALU_R, CL_ALU_I: state_d = S_WB;
          CL_LOAD, CL_STORE:  state_d = S_MEM;
          default:            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready_i) state_d = (cls == CL_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: state_d = S_FETCH;
`ifdef MCU_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control outputs: combinational from state, IR and the handshake inputs.
  // Everything is forced low while reset is asserted.
  // ---------------------------------------------------------------------------
  logic [3:0] op4;

  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    pc_src_o       = 1'b0;
    alu_src_a_o    = 1'b0;
    alu_src_b_o    = 1'b0;
    op4            = OP_ADD;
    reg_write_o    = 1'b0;
    mem_to_reg_o   = 1'b0;
    retire_o       = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
          end
        end
        S_EXEC: begin
          alu_src_b_o = dec_src_b;
          op4         = dec_op;
          if (cls == CL_BRANCH) begin
            pc_write_o = cond_i;
            pc_src_o   = cond_i;
            retire_o   = 1'b1;
          end else if (cls == CL_NOP) begin
            retire_o = 1'b1;
          end
        end
        S_MEM: begin
          // ALU keeps producing the effective address while the access waits.
          alu_src_b_o    = dec_src_b;
          op4            = dec_op;
          mem_req_o      = 1'b1;
          mem_addr_sel_o = 1'b1;
          mem_we_o       = (cls == CL_STORE);
          retire_o       = (cls == CL_STORE) && mem_ready_i;
        end
        S_WB: begin
          alu_src_b_o  = dec_src_b;
          op4          = dec_op;
          reg_write_o  = 1'b1;
          mem_to_reg_o = (cls == CL_LOAD);
          retire_o     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_op_o = ALUOP_W'(op4);

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_FETCH;
      ir_q         <= RESET_IR;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      if (retire_o) retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  assign ir_o         = ir_q;
  assign state_o      = state_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: builds the expected per-cycle
// trace of each instruction from its class and wait states, drives the memory
// handshake from that trace and compares every control output each cycle.

module tb_multicycle_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        cond_i;
  logic [31:0] ir_o;
  logic [2:0]  state_o;
  logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o;
  logic        pc_src_o, alu_src_a_o, alu_src_b_o, reg_write_o, mem_to_reg_o;
  logic        retire_o;
  logic [3:0]  alu_op_o;
  logic [31:0] retire_cnt_o;

  multicycle_control_unit dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ready_i    (mem_ready_i),
    .cond_i         (cond_i),
    .ir_o           (ir_o),
    .state_o        (state_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_sel_o (mem_addr_sel_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .pc_src_o       (pc_src_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_o       (alu_op_o),
    .reg_write_o    (reg_write_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .retire_o       (retire_o),
    .retire_cnt_o   (retire_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One expected clock cycle of an instruction.
  typedef struct packed {
    logic [2:0] st;
    logic       req, we, asel, irw, pcw, pcs, srcb, regw, m2r, ret;
    logic       rdy, cond, chk_alu, chk_ir;
    logic [3:0] op;
  } rec_t;

  rec_t q[$];

  // Reference classification from the ISA rules:
  // 0=NOP/other, 1=R, 2=I, 3=load, 4=store, 5=branch.
  function automatic int classify(input logic [31:0] ins, output logic [3:0] op,
                                  output logic srcb);
    logic [3:0] alu_tab [0:7];
    logic [3:0] br_tab  [0:7];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    alu_tab = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
    br_tab  = '{4'hA, 4'hB, 4'h0, 4'h0, 4'h3, 4'hC, 4'h4, 4'hD};
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    op = 4'h0; srcb = 1'b0;
    if (opc == 7'b0110011) begin
      if (f7 == 7'h00) begin op = alu_tab[f3]; return 1; end
      if (f7 == 7'h20 && f3 == 3'd0) begin op = 4'h1; return 1; end
      if (f7 == 7'h20 && f3 == 3'd5) begin op = 4'h7; return 1; end
      return 0;
    end
    if (opc == 7'b0010011) begin
      op = (f3 == 3'd5 && ins[30]) ? 4'h7 : alu_tab[f3];
      srcb = 1'b1;
      return 2;
    end
    if (opc == 7'b0000011 && f3 == 3'd2) begin srcb = 1'b1; return 3; end
    if (opc == 7'b0100011 && f3 == 3'd2) begin srcb = 1'b1; return 4; end
    if (opc == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin op = br_tab[f3]; return 5; end
    return 0;
  endfunction

  // Expand one instruction into its expected cycle trace.
  task automatic build(input logic [31:0] ins, input int wf, input int wm, input logic cnd);
    rec_t r;
    logic [3:0] op;
    logic srcb;
    int c;
    c = classify(ins, op, srcb);
    for (int i = 0; i <= wf; i++) begin
      r = '0; r.st = 3'd0; r.req = 1'b1; r.cond = 1'($urandom);
      if (i == wf) begin r.rdy = 1'b1; r.irw = 1'b1; r.pcw = 1'b1; end
      q.push_back(r);
    end
    r = '0; r.st = 3'd1; r.rdy = 1'($urandom); r.cond = 1'($urandom); r.chk_ir = 1'b1;
    q.push_back(r);
    r = '0; r.st = 3'd2; r.rdy = 1'($urandom); r.chk_ir = 1'b1;
    r.cond = (c == 5) ? cnd : 1'($urandom);
    if (c != 0) begin r.chk_alu = 1'b1; r.op = op; r.srcb = srcb; end
    if (c == 5) begin r.pcw = cnd; r.pcs = cnd; end
    if (c == 0 || c == 5) r.ret = 1'b1;
    q.push_back(r);
    if (c == 3 || c == 4) begin
      for (int i = 0; i <= wm; i++) begin
        r = '0; r.st = 3'd3; r.req = 1'b1; r.asel = 1'b1; r.we = (c == 4);
        r.chk_ir = 1'b1; r.cond = 1'($urandom);
        if (i == wm) begin r.rdy = 1'b1; r.ret = (c == 4); end
        q.push_back(r);
      end
    end
    if (c == 1 || c == 2 || c == 3) begin
      r = '0; r.st = 3'd4; r.regw = 1'b1; r.m2r = (c == 3); r.ret = 1'b1;
      r.chk_alu = 1'b1; r.op = op; r.srcb = srcb; r.chk_ir = 1'b1;
      r.rdy = 1'($urandom); r.cond = 1'($urandom);
      q.push_back(r);
    end
  endtask

  // Called just after a falling edge: drive, check, advance to next falling edge.
  task automatic run_rec(input rec_t r, input logic [31:0] ins);
    mem_ready_i = r.rdy;
    cond_i      = r.cond;
    mem_rdata_i = (r.st == 3'd0) ? ins : $urandom;
    #1;
    chk("state", 32'(state_o), 32'(r.st));
    chk("mem_req", 32'(mem_req_o), 32'(r.req));
    chk("mem_we", 32'(mem_we_o), 32'(r.we));
    chk("addr_sel", 32'(mem_addr_sel_o), 32'(r.asel));
    chk("ir_write", 32'(ir_write_o), 32'(r.irw));
    chk("pc_write", 32'(pc_write_o), 32'(r.pcw));
    chk("pc_src", 32'(pc_src_o), 32'(r.pcs));
    chk("reg_write", 32'(reg_write_o), 32'(r.regw));
    chk("mem_to_reg", 32'(mem_to_reg_o), 32'(r.m2r));
    chk("retire", 32'(retire_o), 32'(r.ret));
    chk("retire_cnt", retire_cnt_o, exp_cnt);
    if (r.chk_alu) begin
      chk("alu_op", 32'(alu_op_o), 32'(r.op));
      chk("alu_src_b", 32'(alu_src_b_o), 32'(r.srcb));
      chk("alu_src_a", 32'(alu_src_a_o), 32'd0);
    end
    if (r.chk_ir) chk("ir", ir_o, ins);
    if (r.ret) exp_cnt = exp_cnt + 32'd1;
    @(negedge clk_i);
  endtask

  task automatic run_instr(input logic [31:0] ins, input int wf, input int wm, input logic cnd);
    build(ins, wf, wm, cnd);
    while (q.size() > 0) run_rec(q.pop_front(), ins);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
    chk({tag, "_irw"}, 32'(ir_write_o), 32'd0);
    chk({tag, "_pcw"}, 32'(pc_write_o), 32'd0);
    chk({tag, "_regw"}, 32'(reg_write_o), 32'd0);
    chk({tag, "_ret"}, 32'(retire_o), 32'd0);
  endtask

  logic [6:0]  opc_tab [0:6];
  logic [31:0] ins;
  logic [2:0]  f3;
  logic [6:0]  f7;

  initial begin
    opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b1101111};
    rst_i = 1'b1; mem_ready_i = 1'b1; cond_i = 1'b0; mem_rdata_i = 32'h0;
    exp_cnt = 32'd0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ir", ir_o, 32'h00000013);
    chk("rst_cnt", retire_cnt_o, 32'd0);
    check_reset_outputs("rst");
    rst_i = 1'b0;

    // Directed cases.
    run_instr(32'h00500093, 0, 0, 1'b0);   // addi x1,x0,5
    chk("cnt_after_addi", retire_cnt_o, 32'd1);
    run_instr(32'h0080A283, 2, 2, 1'b0);   // lw x5,8(x1), 9 cycles
    run_instr(32'h0050A623, 0, 0, 1'b0);   // sw
    run_instr(32'h00208463, 0, 0, 1'b1);   // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0);   // beq not taken
    run_instr(32'h4030D213, 0, 0, 1'b0);   // srai
    run_instr(32'hFFF08093, 1, 0, 1'b0);   // addi -1, must stay ADD
    run_instr(32'h40208033, 0, 0, 1'b0);   // sub
    run_instr(32'h0000A037, 0, 0, 1'b0);   // lui -> NOP

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      ins[6:0] = opc_tab[$urandom_range(0, 6)];
      f3 = 3'($urandom);
      if ((ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) && $urandom_range(0, 3) != 0)
        f3 = 3'd2;
      ins[14:12] = f3;
      case ($urandom_range(0, 3))
        0:       f7 = 7'($urandom);
        1:       f7 = 7'h20;
        default: f7 = 7'h00;
      endcase
      if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) ins[31:25] = f7;
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    // Reset in the MEM state of a store aborts it without retiring.
    build(32'h0050A623, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) run_rec(q.pop_front(), 32'h0050A623);
    q.delete();
    rst_i = 1'b1; mem_ready_i = 1'b1;
    #1;
    chk("abort_state_before", 32'(state_o), 32'd3);
    check_reset_outputs("abort");
    @(negedge clk_i);
    #1;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_ir", ir_o, 32'h00000013);
    chk("abort_cnt", retire_cnt_o, 32'd0);
    check_reset_outputs("abort_hold");
    exp_cnt = 32'd0;
    rst_i = 1'b0;
    run_instr(32'h00500093, 0, 0, 1'b0);
    chk("cnt_after_abort", retire_cnt_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
